alu_pipe: RTL

- Parameterised, two-stage pipelined successor to the combinational operator block.
- Covers arithmetic, shift, relational, equality, bitwise, reduction, logical, concatenation and conditional operator classes, selected by an opcode.
- Adds a running accumulator, result flags and valid/ready handshakes on both sides.
- Sits between an operand producer and a result consumer in the combinational_circuit study area.
- Serves as the reusable datapath for later sequential exercises.

---
 rtl/alu_pipe_if.sv | 36 +++
 rtl/alu_pipe.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/alu_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_pipe_if
// Description : Operand-side and result-side valid/ready bundle for alu_pipe.
//               The producer drives the operand side and accepts results;
//               the pipeline drives in_ready and the result side.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_pipe_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;

  // Producer/consumer side (testbench or upstream logic)
  modport master (
    output in_valid, op, a, b, c, out_ready,
    input  in_ready, out_valid, result, carry, zero
  );

  // Pipeline side
  modport slave (
    input  in_valid, op, a, b, c, out_ready,
    output in_ready, out_valid, result, carry, zero
  );
endinterface
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : alu_pipe
// Description : Two-stage pipelined operator block with running accumulator,
//               carry/zero flags and valid/ready handshakes on both sides.
//               S1 captures the operands, S2 computes and registers the
//               result. No skid buffer: in_ready is combinational from
//               out_ready.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_pipe #(
  parameter int WIDTH     = 4,
  parameter int ACC_RESET = 0
) (
  input  logic        clk,
  input  logic        rst,
  alu_pipe_if.slave   bus
);

  localparam logic [WIDTH-1:0] C_ACC_INIT = WIDTH'(ACC_RESET);
  localparam int               C_HALF     = WIDTH / 2;

  localparam logic [3:0] C_OP_ADD  = 4'd0;
  localparam logic [3:0] C_OP_SUB  = 4'd1;
  localparam logic [3:0] C_OP_SHL  = 4'd2;
  localparam logic [3:0] C_OP_SHR  = 4'd3;
  localparam logic [3:0] C_OP_SRA  = 4'd4;
  localparam logic [3:0] C_OP_LT   = 4'd5;
  localparam logic [3:0] C_OP_EQ   = 4'd6;
  localparam logic [3:0] C_OP_AND  = 4'd7;
  localparam logic [3:0] C_OP_OR   = 4'd8;
  localparam logic [3:0] C_OP_XOR  = 4'd9;
  localparam logic [3:0] C_OP_RED  = 4'd10;
  localparam logic [3:0] C_OP_LAND = 4'd11;
  localparam logic [3:0] C_OP_CAT  = 4'd12;
  localparam logic [3:0] C_OP_SEL  = 4'd13;
  localparam logic [3:0] C_OP_ACC  = 4'd14;
  localparam logic [3:0] C_OP_CLR  = 4'd15;

  // Stage 1 registers
  logic             r_s1_valid;
  logic [3:0]       r_s1_op;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic [WIDTH-1:0] r_s1_c;

  // Stage 2 / output registers and accumulator
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_zero;
  logic [WIDTH-1:0] r_acc;

  // Combinational datapath
  logic             w_s2_free;
  logic             w_s1_free;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH:0]   w_acc_sum;
  logic [WIDTH-1:0] w_res;
  logic             w_cy;
  logic             w_acc_we;
  logic [WIDTH-1:0] w_acc_next;

  assign w_s2_free    = !r_out_valid || bus.out_ready;
  assign w_s1_free    = !r_s1_valid || w_s2_free;
  assign bus.in_ready = w_s1_free;

  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.carry     = r_carry;
  assign bus.zero      = r_zero;

  // Widened adders expose carry-out and borrow in the top bit
  assign w_sum     = {1'b0, r_s1_a} + {1'b0, r_s1_b};
  assign w_diff    = {1'b0, r_s1_a} - {1'b0, r_s1_b};
  assign w_acc_sum = {1'b0, r_acc}  + {1'b0, r_s1_a};

  // Opcode decode and result/carry/accumulator-next computation for S2
  always_comb begin
    w_res      = '0;
    w_cy       = 1'b0;
    w_acc_we   = 1'b0;
    w_acc_next = r_acc;
    case (r_s1_op)
      C_OP_ADD:  begin w_res = w_sum[WIDTH-1:0];  w_cy = w_sum[WIDTH];  end
      C_OP_SUB:  begin w_res = w_diff[WIDTH-1:0]; w_cy = w_diff[WIDTH]; end
      // Shift amount is the full b value; SV shifts already yield 0
      // (or sign fill for >>>) once the amount reaches WIDTH.
      C_OP_SHL:  w_res = r_s1_a << r_s1_b;
      C_OP_SHR:  w_res = r_s1_a >> r_s1_b;
      C_OP_SRA:  w_res = $unsigned($signed(r_s1_a) >>> r_s1_b);
      C_OP_LT:   w_res = {{(WIDTH-1){1'b0}}, (r_s1_a < r_s1_b)};
      C_OP_EQ:   w_res = {{(WIDTH-1){1'b0}}, (r_s1_a == r_s1_b)};
      C_OP_AND:  w_res = r_s1_a & r_s1_b;
      C_OP_OR:   w_res = r_s1_a | r_s1_b;
      C_OP_XOR:  w_res = r_s1_a ^ r_s1_b;
      C_OP_RED:  w_res = {{(WIDTH-3){1'b0}}, ^r_s1_a, |r_s1_a, &r_s1_a};
      C_OP_LAND: w_res = {{(WIDTH-1){1'b0}}, ((|r_s1_a) && (|r_s1_b))};
      C_OP_CAT:  w_res = {r_s1_a[C_HALF-1:0], r_s1_b[C_HALF-1:0]};
      C_OP_SEL:  w_res = r_s1_c[0] ? r_s1_a : r_s1_b;
      C_OP_ACC:  begin
        w_acc_we   = 1'b1;
        w_acc_next = w_acc_sum[WIDTH-1:0];
        w_res      = w_acc_sum[WIDTH-1:0];
        w_cy       = w_acc_sum[WIDTH];
      end
      C_OP_CLR:  begin
        w_acc_we   = 1'b1;
        w_acc_next = C_ACC_INIT;
        w_res      = C_ACC_INIT;
      end
      default:   w_res = '0;
    endcase
  end

  // S1: capture a new operand set whenever the stage can move
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= '0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_c     <= '0;
    end else if (w_s1_free) begin
      r_s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_s1_op <= bus.op;
        r_s1_a  <= bus.a;
        r_s1_b  <= bus.b;
        r_s1_c  <= bus.c;
      end
    end
  end

  // S2: register result/flags and commit the accumulator as S1 advances
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_carry     <= 1'b0;
      r_zero      <= 1'b0;
      r_acc       <= C_ACC_INIT;
    end else if (w_s2_free) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_result <= w_res;
        r_carry  <= w_cy;
        r_zero   <= (w_res == '0);
        if (w_acc_we) begin
          r_acc <= w_acc_next;
        end
      end
    end
  end

endmodule
`default_nettype wire
